auth_tag_framer: RTL

//  - Downstream consumer of the LFSR key generator. Takes a message stream (valid/ready)
//    and computes an 8-bit authentication tag per frame from payload, keystream and

---
 rtl/auth_tag_framer.sv | 105 ++++++++++
 1 files changed

// File: rtl/auth_tag_framer.sv
// auth_tag_framer: forwards payload beats and appends a keyed 8-bit MAC tag beat per frame.
// Optional AUTH_ERR_CNT_EN adds a saturating err_count of truncated frames.
module auth_tag_framer #(
    parameter int DATA_WIDTH     = 32,
    parameter int KEY_WIDTH      = 256,
    parameter int AUTH_TAG_WIDTH = 8,
    parameter int MAX_BEATS      = 16
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [KEY_WIDTH-1:0]      key_in,
    input  logic [AUTH_TAG_WIDTH-1:0] tag_in,
    input  logic                      msg_valid,
    input  logic [DATA_WIDTH-1:0]     msg_data,
    input  logic                      msg_last,
    output logic                      msg_ready,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_last,
    input  logic                      out_ready,
`ifdef AUTH_ERR_CNT_EN
    output logic [7:0]                err_count,
`endif
    output logic                      frame_err
);
    localparam int T = AUTH_TAG_WIDTH;
    localparam int K = KEY_WIDTH / T;
    localparam int IW = MAX_BEATS > 1 ? $clog2(MAX_BEATS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, TAG} state_t;

    state_t                state, state_next;
    logic [T-1:0]          acc, acc_in, acc_next, fold, tagk_snap;
    logic [KEY_WIDTH-1:0]  key_snap, key_cur;
    logic [IW-1:0]         idx, bidx;
    logic                  slot_free, accept, is_last, trunc, load_tag;
    int                    kbase;

    // Beat 0 sees the live key/tag inputs, which are exactly what gets snapshotted on its edge.
    always_comb begin
        slot_free  = !out_valid || out_ready;
        msg_ready  = (state == IDLE || state == PAYLOAD) && slot_free;
        accept     = msg_valid && msg_ready;
        bidx       = state == IDLE ? '0 : idx;
        acc_in     = state == IDLE ? '0 : acc;
        key_cur    = state == IDLE ? key_in : key_snap;
        is_last    = msg_last || bidx == LAST_IDX;
        trunc      = accept && !msg_last && bidx == LAST_IDX;
        load_tag   = state == TAG && slot_free;
        kbase      = (int'(bidx) % K) * T;
        fold       = '0;
        for (int j = 0; j < DATA_WIDTH / T; j++)
            fold ^= msg_data[j*T +: T];
        acc_next   = {acc_in[T-2:0], acc_in[T-1]} ^ fold ^ key_cur[kbase +: T];
        state_next = state;
        if (accept)
            state_next = is_last ? TAG : PAYLOAD;
        else if (load_tag)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            key_snap  <= '0;
            tagk_snap <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= trunc;
            if (accept) begin
                acc       <= acc_next;
                idx       <= is_last ? '0 : bidx + 1'b1;
                out_valid <= 1'b1;
                out_data  <= msg_data;
                out_last  <= 1'b0;
                if (state == IDLE) begin
                    key_snap  <= key_in;
                    tagk_snap <= tag_in;
                end
            end else if (load_tag) begin
                out_valid <= 1'b1;
                out_data  <= DATA_WIDTH'(acc ^ tagk_snap);
                out_last  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef AUTH_ERR_CNT_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            err_count <= '0;
        else if (trunc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif
endmodule
